// File: rtl/nnrv_mem_arb.sv
// nnrv_mem_arb: N-port arbiter in front of a single-port synchronous RAM.
// A word-addressed GPIO register is decoded at GPIO_ADDR and is never sent to
// the RAM. Each request is accepted in one cycle, accesses the RAM or GPIO in
// the next cycle, and completes in the cycle after that (IDLE/RESP -> ACCESS -> RESP).
module nnrv_mem_arb #(
    parameter int NUM_PORTS  = 2,
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ARB_MODE   = 0,
    parameter int GPIO_ADDR  = 40
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_PORTS-1:0]            i_req_valid,
    output logic [NUM_PORTS-1:0]            o_req_ready,
    input  logic [NUM_PORTS-1:0]            i_req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_PORTS*4-1:0]          i_req_mask,
    input  logic [NUM_PORTS*XLEN-1:0]       i_req_wdata,
    output logic [NUM_PORTS-1:0]            o_rsp_valid,
    output logic [XLEN-1:0]                 o_rsp_rdata,
    output logic                            o_ram_en,
    output logic                            o_ram_we,
    output logic [ADDR_WIDTH-1:0]           o_ram_addr,
    output logic [3:0]                      o_ram_mask,
    output logic [XLEN-1:0]                 o_ram_wdata,
    input  logic [XLEN-1:0]                 i_ram_rdata,
    output logic [XLEN-1:0]                 o_gpio
);

    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [PORT_W-1:0]      rr_ptr;
    logic [PORT_W-1:0]      win_idx;
    logic                   win_found;
    logic                   accept;
    int                     cand;

    logic                   lat_we;
    logic                   lat_gpio;
    logic [PORT_W-1:0]      lat_port;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [3:0]             lat_mask;
    logic [XLEN-1:0]        lat_wdata;
    logic [XLEN-1:0]        gpio_q;
    logic [ADDR_WIDTH-1:0]  win_addr;

    // Pick the winning port: lowest index (fixed) or first after rr_ptr (round-robin).
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        if (ARB_MODE == 0) begin
            // Scan downward so the lowest valid index is the last (winning) assignment.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (i_req_valid[i]) begin
                    win_found = 1'b1;
                    win_idx   = PORT_W'(i);
                end
            end
        end else begin
            // Offsets NUM_PORTS..1 from the pointer; offset 1 (just after last grant) wins.
            for (int i = NUM_PORTS; i >= 1; i--) begin
                cand = int'(rr_ptr) + i;
                if (cand >= NUM_PORTS) begin
                    cand = cand - NUM_PORTS;
                end
                if (i_req_valid[cand]) begin
                    win_found = 1'b1;
                    win_idx   = PORT_W'(cand);
                end
            end
        end
    end

    // A grant is only offered outside ACCESS and never while reset is held.
    assign accept   = (state != ACCESS) && win_found && i_rst;
    assign win_addr = i_req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= state_next;
        end
    end

    // Next-state logic: ACCESS always lasts exactly one cycle.
    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE, RESP: state_next = accept ? ACCESS : IDLE;
            ACCESS:     state_next = RESP;
            default:    state_next = IDLE;
        endcase
    end

    // Capture the winning request and advance the round-robin pointer on grant.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            // NOTE: every register here is a plain flop, so all of them get an explicit reset value.
            rr_ptr    <= PORT_W'(NUM_PORTS - 1);
            lat_we    <= 1'b0;
            lat_gpio  <= 1'b0;
            lat_port  <= '0;
            lat_addr  <= '0;
            lat_mask  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            rr_ptr    <= win_idx;
            lat_port  <= win_idx;
            lat_we    <= i_req_we[win_idx];
            lat_addr  <= win_addr;
            lat_gpio  <= (win_addr == ADDR_WIDTH'(GPIO_ADDR));
            lat_mask  <= i_req_mask[int'(win_idx)*4 +: 4];
            lat_wdata <= i_req_wdata[int'(win_idx)*XLEN +: XLEN];
        end
    end

    // GPIO register: byte-masked write at the end of a GPIO ACCESS (XLEN >= 32 assumed).
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            gpio_q <= '0;
        end else if (state == ACCESS && lat_gpio && lat_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_mask[b]) begin
                    gpio_q[b*8 +: 8] <= lat_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Output decode: RAM strobe in ACCESS, completion in RESP, zeros otherwise.
    always_comb begin
        o_req_ready = '0;
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_mask  = '0;
        o_ram_wdata = '0;
        o_rsp_valid = '0;
        o_rsp_rdata = '0;
        if (accept) begin
            o_req_ready[win_idx] = 1'b1;
        end
        if (state == ACCESS && !lat_gpio) begin
            o_ram_en    = 1'b1;
            o_ram_we    = lat_we;
            o_ram_addr  = lat_addr;
            o_ram_mask  = lat_mask;
            o_ram_wdata = lat_wdata;
        end
        if (state == RESP) begin
            o_rsp_valid[lat_port] = 1'b1;
            if (!lat_we) begin
                o_rsp_rdata = lat_gpio ? gpio_q : i_ram_rdata;
            end
        end
    end

    assign o_gpio = gpio_q;

endmodule
